// File: rtl/arc_mem_pkg.sv
// Shared definitions for the ARC memory access path: FSM states, bus widths
// and the start of user address space.
package arc_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] USER_BASE = 32'd2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Bus master between the ARC control unit and main memory: one request at a
// time in, memory rd/wr pins out, registered response back.
module mem_access_unit
    import arc_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_LATENCY  = 1,
    parameter int WAIT_STATES = 0,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on any rising clk edge where valid and
    // ready are both 1; valid never waits on ready, and ready is registered.

    localparam int CNT_MAX = RD_LATENCY + WAIT_STATES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    // mem_rd drops one count before the capture so data_out has settled.
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] RD_DROP = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WAIT_STATES);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              req_ready_d, resp_valid_d, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_rd_d, mem_wr_d;
    logic              misaligned;

    assign misaligned = (ALIGN_CHECK != 0) && (req_addr[1:0] != 2'b00);
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_rd     <= mem_rd_d;
            mem_wr     <= mem_wr_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_err_d   = resp_err;
        resp_rdata_d = resp_rdata;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_rd_d     = mem_rd;
        mem_wr_d     = mem_wr;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d  = WRITE;
                        mem_wr_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt == RD_LAST) begin
                    state_d      = RESP;
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == RD_DROP) begin
                        mem_rd_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (cnt == WR_LAST) begin
                    state_d      = RESP;
                    cnt_d        = '0;
                    mem_wr_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: a default instance and a two-wait-state
// instance share the request pins, each backed by its own memory model.
module tb_mem_access_unit;
    import arc_mem_pkg::*;

    localparam int RD_LAT = 1;

    logic        clk, rst;
    logic        req_valid, req_we, resp_ready, sel;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  vld, rr, rv, rerr, mrd, mwr;
    logic [31:0] rdata [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];
    logic [31:0] mrdata [2];
    logic [1:0]  dbg [2];

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] ref_mem [2][256];
    logic [32:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    assign vld = {req_valid & sel, req_valid & ~sel};

    mem_access_unit dut0 (
        .clk(clk), .rst(rst),
        .req_valid(vld[0]), .req_ready(rr[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_ready(resp_ready),
        .resp_rdata(rdata[0]), .resp_err(rerr[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_rd(mrd[0]), .mem_wr(mwr[0]), .mem_rdata(mrdata[0]),
        .dbg_state(dbg[0])
    );

    mem_access_unit #(.WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(vld[1]), .req_ready(rr[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_ready(resp_ready),
        .resp_rdata(rdata[1]), .resp_err(rerr[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_rd(mrd[1]), .mem_wr(mwr[1]), .mem_rdata(mrdata[1]),
        .dbg_state(dbg[1])
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a - USER_BASE) >> 2) & 255;
    endfunction

    // Memories with registered data_out
    always @(posedge clk) begin
        if (mrd[0]) mrdata[0] <= mem0[widx(maddr[0])];
        if (mwr[0]) mem0[widx(maddr[0])] <= mwdata[0];
        if (mrd[1]) mrdata[1] <= mem1[widx(maddr[1])];
        if (mwr[1]) mem1[widx(maddr[1])] <= mwdata[1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem0[widx(a)] = v;
        mem1[widx(a)] = v;
        ref_mem[0][widx(a)] = v;
        ref_mem[1][widx(a)] = v;
    endtask

    // Driver + scoreboard for one request on instance d; resp_ready held low
    // for `stall` cycles once the response appears.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall);
        int ws, lat, exp_lat, rd_n, wr_n, wait_n;
        logic err;
        logic [32:0] exp;
        ws  = (d == 1) ? 2 : 0;
        err = (addr[1:0] != 2'b00);
        if (err) begin
            exp = {1'b1, 32'h0};
            exp_lat = 1;
        end else if (we) begin
            exp = {1'b0, 32'h0};
            exp_lat = 2 + ws;
            ref_mem[d][widx(addr)] = wdata;
        end else begin
            exp = {1'b0, ref_mem[d][widx(addr)]};
            exp_lat = RD_LAT + ws + 2;
        end
        exp_q.push_back(exp);

        sel = d[0];
        wait_n = 0;
        while (!rr[d] && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("req_ready_idle", rr[d], 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_busy", rr[d], 0);

        lat = 1; rd_n = 0; wr_n = 0;
        while (!rv[d] && lat < 40) begin
            check("rd_wr_excl", mrd[d] & mwr[d], 0);
            if (mrd[d]) begin
                rd_n++;
                check("rd_addr", maddr[d], addr);
            end
            if (mwr[d]) begin
                wr_n++;
                check("wr_addr_data", {maddr[d], mwdata[d]}, {addr, wdata});
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rd_cycles", rd_n, (!err && !we) ? RD_LAT + ws : 0);
        check("wr_cycles", wr_n, (!err && we) ? 1 + ws : 0);
        check("resp", {rerr[d], rdata[d]}, exp_q.pop_front());

        for (int i = 0; i < stall; i++) begin
            check("stall_hold", {rv[d], rr[d], rerr[d], rdata[d]}, {1'b1, 1'b0, exp});
            check("stall_pins_idle", {mrd[d], mwr[d]}, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("post_resp", {rv[d], rerr[d], rr[d], dbg[d]}, {3'b001, IDLE});
        if (!err) check("addr_hold", maddr[d], addr);
    endtask

    initial begin
        logic [31:0] a, v;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b1; sel = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem0[i] = v; mem1[i] = v;
            ref_mem[0][i] = v; ref_mem[1][i] = v;
        end
        preload(32'd2052, 32'hc4002830);
        preload(32'd2120, 32'h81c3e828);
        preload(32'd2096, 32'h00000834);

        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset_ctl", {rr[d], rv[d], rerr[d], mrd[d], mwr[d], dbg[d]}, {5'b10000, IDLE});
            check("reset_data", {rdata[d], maddr[d], mwdata[d]}, 96'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        txn(0, 1'b0, 32'd2052, 32'h0, 0);
        txn(0, 1'b1, 32'd2100, 32'h0000001e, 0);
        txn(0, 1'b0, 32'd2100, 32'h0, 0);
        txn(0, 1'b0, 32'd2050, 32'h0, 0);
        txn(0, 1'b1, 32'd2051, 32'hdeadbeef, 0);
        txn(0, 1'b0, 32'd2120, 32'h0, 3);
        txn(1, 1'b0, 32'd2096, 32'h0, 0);
        txn(1, 1'b1, 32'd2200, 32'h12345678, 1);
        txn(1, 1'b0, 32'd2200, 32'h0, 0);

        // Asynchronous reset in the middle of a read
        sel = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd2120; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("pre_rst_rd", mrd[0], 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_read", {mrd[0], rv[0], rr[0], dbg[0]}, {3'b001, IDLE});
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_rst", {rv[0], rr[0], mrd[0]}, 3'b010);
        end

        // Randomised traffic on both instances
        for (int n = 0; n < 60; n++) begin
            a = USER_BASE + 32'(4 * $urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
